led_breathe: RTL

Breathing-LED driver that consumes the one-cycle carry-out pulse of the board's free-running 24-bit counter and drives a single LED pin with a triangle-wave brightness envelope. A free-running PWM counter compares against a brightness level. A four-phase state machine ramps that level up, holds it, ramps it down and holds it again, advancing once per tick. It sits directly downstream of the counter and replaces the raw counter-MSB LED drive on the icestick top level.

---
 rtl/led_breathe.sv | 115 +++++++++++
 1 files changed

// File: rtl/led_breathe.sv
// Breathing-LED driver: a free-running PWM counter compared against a level that
// a four-phase FSM ramps up, holds, ramps down and holds again, one step per tick.
module led_breathe #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int HOLD  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             tick,
  output logic             led,
  output logic [WIDTH-1:0] level,
  output logic [2:0]       state
);

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [WIDTH-1:0] MAX_L     = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pwm_cnt;
  logic [HW-1:0]    hold_q, hold_d;
  logic             led_q;

  // One extra bit on the sum so a large STEP near the top saturates instead of wrapping.
  logic [WIDTH:0] rise_sum;
  logic           ramp_top, ramp_bot, hold_done;

  assign rise_sum  = {1'b0, level_q} + STEP_W;
  assign ramp_top  = rise_sum >= {1'b0, MAX_L};
  assign ramp_bot  = {1'b0, level_q} <= STEP_W;
  assign hold_done = hold_q == HOLD_LAST;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_RISE;
        S_RISE:    if (tick && ramp_top)  state_d = S_HOLD_HI;
        S_HOLD_HI: if (tick && hold_done) state_d = S_FALL;
        S_FALL:    if (tick && ramp_bot)  state_d = S_HOLD_LO;
        S_HOLD_LO: if (tick && hold_done) state_d = S_RISE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Level and hold counter only move on a tick in an active phase.
  always_comb begin
    level_d = level_q;
    hold_d  = hold_q;
    if (!en) begin
      level_d = '0;
      hold_d  = '0;
    end else if (tick) begin
      case (state_q)
        S_RISE: begin
          if (ramp_top) begin
            level_d = MAX_L;
            hold_d  = '0;
          end else begin
            level_d = rise_sum[WIDTH-1:0];
          end
        end
        S_FALL: begin
          if (ramp_bot) begin
            level_d = '0;
            hold_d  = '0;
          end else begin
            level_d = level_q - STEP_W[WIDTH-1:0];
          end
        end
        S_HOLD_HI, S_HOLD_LO: hold_d = hold_done ? '0 : hold_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= '0;
      hold_q  <= '0;
      pwm_cnt <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      hold_q  <= hold_d;
      pwm_cnt <= en ? pwm_cnt + 1'b1 : '0;
      led_q   <= en && (pwm_cnt < level_q);
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign state = state_q;

endmodule
